// File: rtl/cu_command_arbiter_if.sv
// Command arbiter shared types and bus interface.
//   cu_command_arbiter_pkg : command line and buffer status types.
//   cu_command_arbiter_if  : groups the requester-side commands, the downstream
//                            buffer status, the grant strobes and the winning
//                            command.
//     command_in            per-requester head command (.valid = requesting)
//     command_buffer_status downstream buffer status (.alfull = backpressure)
//     grant_out             one-hot pop strobe back to the requesters
//     command_out           registered winning command
//   Modports: slave = arbiter side, master = requester/buffer side.
package cu_command_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  tag;
    logic [31:0] payload;
  } command_buffer_line_t;

  typedef struct packed {
    logic full;
    logic alfull;
  } buffer_status_t;

endpackage

interface cu_command_arbiter_if
  import cu_command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTS = 2
);

  command_buffer_line_t [NUM_REQUESTS-1:0] command_in;
  buffer_status_t                          command_buffer_status;
  logic [NUM_REQUESTS-1:0]                 grant_out;
  command_buffer_line_t                    command_out;

  modport slave (
    input  command_in,
    input  command_buffer_status,
    output grant_out,
    output command_out
  );

  modport master (
    output command_in,
    output command_buffer_status,
    input  grant_out,
    input  command_out
  );

endinterface

// File: rtl/cu_command_arbiter.sv
// Round-robin arbiter letting NUM_REQUESTS engines share one command buffer.
// Ports:
//   clock           single clock, all state on the rising edge
//   rst             asynchronous active-high reset
//   enabled_in      arbiter enable; low forces DISABLED
//   bus             cu_command_arbiter_if.slave (commands, status, grant, output)
//   issue_count_out per-requester issued-command counters, requester i at [32*i +: 32]
//   arb_state_out   registered state encoding
//
// state        | meaning
// -------------+-----------------------------------------------------------
// DISABLED (0) | arbiter off, no grants
// ARBITRATE (1)| grants one requester per cycle while buffer not almost full
// STALL (2)    | downstream almost full, waiting for room
module cu_command_arbiter
  import cu_command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTS = 2
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        enabled_in,
  cu_command_arbiter_if.slave         bus,
  output logic [32*NUM_REQUESTS-1:0]  issue_count_out,
  output logic [1:0]                  arb_state_out
);

  localparam int PTR_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_ARBITRATE = 2'd1,
    ST_STALL     = 2'd2
  } arb_state_t;

  arb_state_t                  state_q, state_d;
  logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]            win_idx, cand;
  logic                        win_found;
  logic                        qualified;
  logic [NUM_REQUESTS-1:0]     grant;
  logic [32*NUM_REQUESTS-1:0]  issue_cnt_q;
  command_buffer_line_t        cmd_d;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    cmd_d     = '0;

    case (state_q)
      ST_DISABLED:  if (enabled_in) state_d = ST_ARBITRATE;
      ST_ARBITRATE: if (bus.command_buffer_status.alfull) state_d = ST_STALL;
      ST_STALL:     if (!bus.command_buffer_status.alfull) state_d = ST_ARBITRATE;
      default:      state_d = ST_DISABLED;
    endcase
    // Disable overrides every other transition.
    if (!enabled_in) state_d = ST_DISABLED;

    // Gating on rst keeps grant_out quiet while reset is held, and gating on
    // alfull suppresses the grant in the ARBITRATE->STALL transition cycle.
    qualified = !rst && enabled_in && (state_q == ST_ARBITRATE) &&
                !bus.command_buffer_status.alfull;

    if (qualified) begin
      for (int k = 0; k < NUM_REQUESTS; k++) begin
        cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQUESTS);
        if (!win_found && bus.command_in[cand].valid) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end

    if (win_found) begin
      grant[win_idx] = 1'b1;
      rr_ptr_d       = PTR_W'((int'(win_idx) + 1) % NUM_REQUESTS);
      cmd_d          = bus.command_in[win_idx];
      cmd_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= ST_DISABLED;
    else     state_q <= state_d;
  end

  // The pointer only moves on a grant, so it survives DISABLED/STALL and
  // fairness picks up where it stopped.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      bus.command_out <= '0;
      issue_cnt_q     <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      bus.command_out <= cmd_d;
      for (int i = 0; i < NUM_REQUESTS; i++) begin
        if (grant[i]) issue_cnt_q[32*i +: 32] <= issue_cnt_q[32*i +: 32] + 32'd1;
      end
    end
  end

  assign bus.grant_out     = grant;
  assign issue_count_out   = issue_cnt_q;
  assign arb_state_out     = state_q;

endmodule

// File: tb/tb_cu_command_arbiter.sv
module tb_cu_command_arbiter;
  import cu_command_arbiter_pkg::*;

  localparam int N = 2;

  logic clock = 1'b0;
  logic rst;
  logic enabled_in;
  logic [32*N-1:0] issue_count_out;
  logic [1:0] arb_state_out;

  cu_command_arbiter_if #(.NUM_REQUESTS(N)) bus_if ();

  cu_command_arbiter #(.NUM_REQUESTS(N)) dut (
    .clock           (clock),
    .rst             (rst),
    .enabled_in      (enabled_in),
    .bus             (bus_if),
    .issue_count_out (issue_count_out),
    .arb_state_out   (arb_state_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic af, input logic [1:0] v,
                       input logic [31:0] pl0, input logic [31:0] pl1);
    enabled_in = en;
    bus_if.command_buffer_status = '{full: 1'b0, alfull: af};
    bus_if.command_in[0] = '{valid: v[0], tag: 4'h3, payload: pl0};
    bus_if.command_in[1] = '{valid: v[1], tag: 4'hC, payload: pl1};
  endtask

  // Reference model: spec-level state number, pointer, counters, expected command.
  int                   m_state;
  int                   m_ptr;
  int unsigned          m_cnt [N];
  command_buffer_line_t m_cmd;

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_cmd   = '0;
  endtask

  task automatic step(input logic en, input logic af, input logic [1:0] v);
    int g;
    logic [N-1:0] exp_g;
    @(negedge clock);
    drive(en, af, v, $urandom, $urandom);
    #1;
    g = -1;
    if (m_state == 1 && en && !af)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_g = '0;
    if (g >= 0) exp_g[g] = 1'b1;
    check("model_grant", 64'(bus_if.grant_out), 64'(exp_g));
    if (!en) m_state = 0;
    else if (m_state == 0) m_state = 1;
    else m_state = af ? 2 : 1;
    if (g >= 0) begin
      m_cnt[g] = m_cnt[g] + 1;
      m_ptr    = (g + 1) % N;
      m_cmd    = bus_if.command_in[g];
    end else begin
      m_cmd = '0;
    end
    @(posedge clock);
    #1;
    check("model_state", 64'(arb_state_out), 64'(m_state));
    check("model_cmd", 64'(bus_if.command_out), 64'(m_cmd));
    check("model_counts", 64'(issue_count_out), {m_cnt[1], m_cnt[0]});
  endtask

  typedef struct {
    logic       en;
    logic       af;
    logic [1:0] v;
    logic [1:0] g;
    logic [1:0] st;
  } vec_t;

  vec_t vq[$];

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    command_buffer_line_t exp_cmd;
    logic [31:0] pl0, pl1, c1_saved;

    // Reset with commands pending, checked before any clock edge.
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b11, 32'h1111_1111, 32'h2222_2222);
    #2;
    check("rst_grant", 64'(bus_if.grant_out), 64'd0);
    check("rst_cmd", 64'(bus_if.command_out), 64'd0);
    check("rst_counts", 64'(issue_count_out), 64'd0);
    check("rst_state", 64'(arb_state_out), 64'd0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clock);
    rst = 1'b0;

    //                en    af    v      grant  state-after
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b00, 2'd1}); // DISABLED -> ARBITRATE
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b01, 2'd1}); // rr 0,1,0,1
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b10, 2'd1});
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b01, 2'd1});
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b10, 2'd1});
    vq.push_back('{1'b1, 1'b1, 2'b11, 2'b00, 2'd2}); // alfull: no grant, STALL
    vq.push_back('{1'b1, 1'b1, 2'b11, 2'b00, 2'd2});
    vq.push_back('{1'b1, 1'b1, 2'b11, 2'b00, 2'd2});
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b00, 2'd1}); // STALL -> ARBITRATE
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b01, 2'd1}); // resumes at rr_ptr=0
    vq.push_back('{1'b0, 1'b0, 2'b11, 2'b00, 2'd0}); // disable mid-stream
    vq.push_back('{1'b0, 1'b0, 2'b11, 2'b00, 2'd0});
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b00, 2'd1});
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b10, 2'd1}); // retained rr_ptr=1
    vq.push_back('{1'b1, 1'b0, 2'b10, 2'b10, 2'd1}); // single requester
    vq.push_back('{1'b1, 1'b0, 2'b10, 2'b10, 2'd1});
    vq.push_back('{1'b1, 1'b0, 2'b10, 2'b10, 2'd1});
    vq.push_back('{1'b1, 1'b0, 2'b10, 2'b10, 2'd1});
    vq.push_back('{1'b1, 1'b0, 2'b10, 2'b10, 2'd1});
    vq.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'd1}); // nobody requesting
    vq.push_back('{1'b1, 1'b0, 2'b01, 2'b01, 2'd1});
    vq.push_back('{1'b1, 1'b0, 2'b11, 2'b10, 2'd1});

    for (int r = 0; r < vq.size(); r++) begin
      @(negedge clock);
      pl0 = 32'hA000_0000 + 32'(r);
      pl1 = 32'hB000_0000 + 32'(r);
      drive(vq[r].en, vq[r].af, vq[r].v, pl0, pl1);
      #1;
      check($sformatf("tbl_grant[%0d]", r), 64'(bus_if.grant_out), 64'(vq[r].g));
      exp_cmd = '0;
      if (vq[r].g[0]) exp_cmd = '{valid: 1'b1, tag: 4'h3, payload: pl0};
      if (vq[r].g[1]) exp_cmd = '{valid: 1'b1, tag: 4'hC, payload: pl1};
      @(posedge clock);
      #1;
      check($sformatf("tbl_state[%0d]", r), 64'(arb_state_out), 64'(vq[r].st));
      check($sformatf("tbl_cmd[%0d]", r), 64'(bus_if.command_out), 64'(exp_cmd));
    end
    check("tbl_counts", 64'(issue_count_out), {32'd9, 32'd4});

    // Asynchronous reset mid-operation drops the in-flight command.
    @(negedge clock);
    drive(1'b1, 1'b0, 2'b11, 32'h5555_0000, 32'h6666_0000);
    @(posedge clock);
    #2;
    check("mid_pre_cmd_valid", 64'(bus_if.command_out.valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_cmd", 64'(bus_if.command_out), 64'd0);
    check("mid_rst_grant", 64'(bus_if.grant_out), 64'd0);
    check("mid_rst_counts", 64'(issue_count_out), 64'd0);
    check("mid_rst_state", 64'(arb_state_out), 64'd0);
    @(negedge clock);
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 32'h7777_0000, 32'h8888_0000);
    #1;
    check("post_rst_no_grant", 64'(bus_if.grant_out), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      #1;
      check($sformatf("single_grant[%0d]", c), 64'(bus_if.grant_out), 64'b10);
    end
    @(posedge clock);
    #1;
    check("single_counts", 64'(issue_count_out), {32'd5, 32'd0});

    // Randomized run against the reference model.
    @(negedge clock);
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clock);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++)
      step(($urandom % 8) != 0, ($urandom % 5) == 0, 2'($urandom % 4));

    // Counter wrap: preload requester 0 at all-ones, then grant it once.
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    c1_saved = m_cnt[1];
    force dut.issue_cnt_q = {c1_saved, 32'hFFFF_FFFF};
    #1;
    release dut.issue_cnt_q;
    m_cnt[0] = 32'hFFFF_FFFF;
    #1;
    check("wrap_preload", 64'(issue_count_out), {c1_saved, 32'hFFFF_FFFF});
    step(1'b1, 1'b0, 2'b01);
    check("wrap_count0", 64'(issue_count_out[31:0]), 64'd0);
    check("wrap_count1", 64'(issue_count_out[63:32]), 64'(c1_saved));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
